// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, dispatcher state encoding and bit-timing
// constants used by the Tx/Rx instances and the transmit queue.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    // 25 MHz system clock / 115200 baud.
    localparam int CLKS_PER_BIT_115200 = 217;
    localparam int CLKS_PER_BIT        = CLKS_PER_BIT_115200;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } tx_q_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with registered pointers, count, full/empty flags and a
// sticky overflow flag for pushes dropped while full.
module byte_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Wr_En,
    input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
    input  logic                   i_Clr_Ovf,
    input  logic                   i_Pop,
    output logic [UART_BYTE_W-1:0] o_Head_Byte,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [ADDR_W:0]        o_Count,
    output logic                   o_Overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [UART_BYTE_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]        count_q, count_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   ovf_q, ovf_d;
    logic                   push;
    logic                   pop;

    always_comb begin
        // Full is judged on the registered flag, so a pop on the same edge
        // never makes room for a push.
        push     = i_Wr_En && !full_q;
        pop      = i_Pop && !empty_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
        ovf_d   = ovf_q;
        if (i_Clr_Ovf)          ovf_d = 1'b0;
        if (i_Wr_En && full_q)  ovf_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: storage is deliberately not reset; clearing the pointers and count
    // already discards its contents, and a reset-free array maps onto RAM.
    always_ff @(posedge i_Clock) begin
        if (push) mem_q[wr_ptr_q] <= i_Wr_Byte;
    end

    assign o_Head_Byte = mem_q[rd_ptr_q];
    assign o_Full      = full_q;
    assign o_Empty     = empty_q;
    assign o_Count     = count_q;
    assign o_Overflow  = ovf_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and dispatcher for the UART transmitter: strobes one byte at a
// time into Tx and waits for its done pulse plus a cleanup cycle before the next.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Wr_En,
    input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
    input  logic                   i_Clr_Ovf,
    input  logic                   i_Tx_Done,
    output logic                   o_Tx_DV,
    output logic [UART_BYTE_W-1:0] o_Tx_Byte,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [ADDR_W:0]        o_Count,
    output logic                   o_Busy,
    output logic                   o_Overflow
);

    tx_q_state_t            state_q, state_d;
    logic                   tx_dv_q, tx_dv_d;
    logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic                   busy_q, busy_d;
    logic                   pop;
    logic [UART_BYTE_W-1:0] head_byte;
    logic                   fifo_empty;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Wr_En     (i_Wr_En),
        .i_Wr_Byte   (i_Wr_Byte),
        .i_Clr_Ovf   (i_Clr_Ovf),
        .i_Pop       (pop),
        .o_Head_Byte (head_byte),
        .o_Full      (o_Full),
        .o_Empty     (fifo_empty),
        .o_Count     (o_Count),
        .o_Overflow  (o_Overflow)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = SEND;
                    pop       = 1'b1;
                    tx_byte_d = head_byte;
                end
            end
            SEND:    state_d = WAIT;
            WAIT:    if (i_Tx_Done) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        tx_dv_d = (state_d == SEND);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            busy_q    <= busy_d;
        end
    end

    assign o_Tx_DV   = tx_dv_q;
    assign o_Tx_Byte = tx_byte_q;
    assign o_Busy    = busy_q;
    assign o_Empty   = fifo_empty;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue (DEPTH=4) against a queue-based
// reference model and a behavioural Tx that pulses done 20 cycles after its strobe.
module tb_uart_tx_queue;

    localparam int DEPTH = 4;

    logic       i_Clock = 1'b0;
    logic       i_Reset;
    logic       i_Wr_En;
    logic [7:0] i_Wr_Byte;
    logic       i_Clr_Ovf;
    logic       i_Tx_Done;
    logic       o_Tx_DV;
    logic [7:0] o_Tx_Byte;
    logic       o_Full;
    logic       o_Empty;
    logic [2:0] o_Count;
    logic       o_Busy;
    logic       o_Overflow;

    always #5 i_Clock = ~i_Clock;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Wr_En    (i_Wr_En),
        .i_Wr_Byte  (i_Wr_Byte),
        .i_Clr_Ovf  (i_Clr_Ovf),
        .i_Tx_Done  (i_Tx_Done),
        .o_Tx_DV    (o_Tx_DV),
        .o_Tx_Byte  (o_Tx_Byte),
        .o_Full     (o_Full),
        .o_Empty    (o_Empty),
        .o_Count    (o_Count),
        .o_Busy     (o_Busy),
        .o_Overflow (o_Overflow)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    int    edge_n = 0;
    int    dut_dv_cnt = 0;
    string phase = "reset0";

    // Reference model: pending bytes, one transfer in flight, earliest next pop.
    byte unsigned m_q[$];
    logic         m_xfer;
    int           m_pop_e;
    int           m_last_done;
    int           m_allow_e;
    logic         m_ovf;
    logic [7:0]   m_byte;
    logic         m_dv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_xfer      = 1'b0;
        m_pop_e     = -100;
        m_last_done = -100;
        m_allow_e   = 0;
        m_ovf       = 1'b0;
        m_byte      = 8'h00;
        m_dv        = 1'b0;
    endtask

    task automatic check_all();
        check({phase, ".dv"},    32'(o_Tx_DV),    32'(m_dv));
        check({phase, ".byte"},  32'(o_Tx_Byte),  32'(m_byte));
        check({phase, ".count"}, 32'(o_Count),    32'(m_q.size()));
        check({phase, ".full"},  32'(o_Full),     32'(m_q.size() == DEPTH));
        check({phase, ".empty"}, 32'(o_Empty),    32'(m_q.size() == 0));
        check({phase, ".busy"},  32'(o_Busy),     32'(m_xfer || (edge_n <= m_last_done)));
        check({phase, ".ovf"},   32'(o_Overflow), 32'(m_ovf));
    endtask

    task automatic step(input logic wr, input logic [7:0] b, input logic clr);
        int   e;
        logic done;
        logic full;
        logic pop;
        e    = edge_n + 1;
        done = m_xfer && (e == m_pop_e + 21);
        if (!m_xfer && ($urandom_range(7) == 0)) done = 1'b1;
        i_Wr_En   = wr;
        i_Wr_Byte = b;
        i_Clr_Ovf = clr;
        i_Tx_Done = done;
        @(posedge i_Clock);
        edge_n = e;
        pop  = (m_q.size() != 0) && !m_xfer && (e >= m_allow_e);
        full = (m_q.size() == DEPTH);
        if (m_xfer && done) begin
            m_xfer      = 1'b0;
            m_last_done = e;
            m_allow_e   = e + 2;
        end
        m_dv = pop;
        if (pop) begin
            m_byte  = m_q.pop_front();
            m_xfer  = 1'b1;
            m_pop_e = e;
        end
        if (wr && !full) m_q.push_back(b);
        if (wr && full)  m_ovf = 1'b1;
        else if (clr)    m_ovf = 1'b0;
        #1;
        i_Wr_En   = 1'b0;
        i_Clr_Ovf = 1'b0;
        i_Tx_Done = 1'b0;
        if (o_Tx_DV === 1'b1) dut_dv_cnt++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_reset_values();
        check({phase, ".rst_dv"},    32'(o_Tx_DV),    32'd0);
        check({phase, ".rst_byte"},  32'(o_Tx_Byte),  32'h00);
        check({phase, ".rst_full"},  32'(o_Full),     32'd0);
        check({phase, ".rst_empty"}, 32'(o_Empty),    32'd1);
        check({phase, ".rst_count"}, 32'(o_Count),    32'd0);
        check({phase, ".rst_busy"},  32'(o_Busy),     32'd0);
        check({phase, ".rst_ovf"},   32'(o_Overflow), 32'd0);
    endtask

    initial begin
        int guard;
        int sent;
        int dv_base;

        i_Reset   = 1'b1;
        i_Wr_En   = 1'b0;
        i_Wr_Byte = 8'h00;
        i_Clr_Ovf = 1'b0;
        i_Tx_Done = 1'b0;
        model_reset();
        repeat (2) @(posedge i_Clock);
        #1;
        check_reset_values();
        i_Reset = 1'b0;

        // Single byte: strobe one cycle after the push edge's successor.
        phase = "single";
        step(1'b1, 8'hA5, 1'b0);
        check("single.empty_fall", 32'(o_Empty), 32'd0);
        idle(1);
        check("single.dv_high", 32'(o_Tx_DV), 32'd1);
        check("single.byte", 32'(o_Tx_Byte), 32'hA5);
        check("single.count0", 32'(o_Count), 32'd0);
        idle(1);
        check("single.dv_low", 32'(o_Tx_DV), 32'd0);
        check("single.busy", 32'(o_Busy), 32'd1);
        idle(30);
        check("single.idle_end", 32'(o_Busy), 32'd0);

        // Burst of four: first byte pops immediately, so the FIFO never fills.
        phase = "burst";
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        check("burst.not_full", 32'(o_Full), 32'd0);
        check("burst.count3", 32'(o_Count), 32'd3);
        idle(120);

        // Overflow while Tx is busy, then clear; set wins over a same-edge clear.
        phase = "ovf";
        step(1'b1, 8'h10, 1'b0);
        idle(2);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
        check("ovf.full", 32'(o_Full), 32'd1);
        step(1'b1, 8'hFF, 1'b0);
        check("ovf.set", 32'(o_Overflow), 32'd1);
        check("ovf.count4", 32'(o_Count), 32'd4);
        step(1'b0, 8'h00, 1'b1);
        check("ovf.clear", 32'(o_Overflow), 32'd0);
        step(1'b1, 8'hEE, 1'b1);
        check("ovf.set_wins", 32'(o_Overflow), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        idle(130);

        // Push on the same edge as a pop with two bytes queued.
        phase = "simul";
        step(1'b1, 8'h30, 1'b0);
        idle(2);
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h32, 1'b0);
        guard = 0;
        while (!((m_q.size() != 0) && !m_xfer && (edge_n + 1 >= m_allow_e)) && guard < 60) begin
            idle(1);
            guard++;
        end
        if (guard >= 60) timeout("simul.wait_pop");
        step(1'b1, 8'h33, 1'b0);
        check("simul.count2", 32'(o_Count), 32'd2);
        check("simul.dv", 32'(o_Tx_DV), 32'd1);
        idle(100);

        // Ten bytes through the four-deep FIFO.
        phase   = "wrap";
        sent    = 0;
        guard   = 0;
        dv_base = dut_dv_cnt;
        while (sent < 10 && guard < 600) begin
            if (m_q.size() < DEPTH && $urandom_range(1) == 1) begin
                step(1'b1, 8'h40 + 8'(sent), 1'b0);
                sent++;
            end else begin
                idle(1);
            end
            guard++;
        end
        if (sent < 10) timeout("wrap.push");
        idle(150);
        check("wrap.ndisp", 32'(dut_dv_cnt - dv_base), 32'd10);

        // Random pushes, clears and stray done pulses.
        phase = "random";
        for (int i = 0; i < 400; i++)
            step($urandom_range(3) == 0, 8'($urandom), $urandom_range(15) == 0);
        idle(150);

        // Asynchronous reset in WAIT with three bytes queued.
        phase = "reset";
        for (int i = 0; i < 4; i++) step(1'b1, 8'h50 + 8'(i), 1'b0);
        idle(5);
        check("reset.count3", 32'(o_Count), 32'd3);
        check("reset.busy", 32'(o_Busy), 32'd1);
        #2;
        i_Reset = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(posedge i_Clock);
        edge_n++;
        #1;
        check_reset_values();
        i_Reset = 1'b0;
        dv_base = dut_dv_cnt;
        idle(40);
        check("reset.no_dv", 32'(dut_dv_cnt - dv_base), 32'd0);
        step(1'b1, 8'h66, 1'b0);
        idle(1);
        check("reset.new_dv", 32'(o_Tx_DV), 32'd1);
        check("reset.new_byte", 32'(o_Tx_Byte), 32'h66);
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
